// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 IF stage with PC, IF/ID register, fault state and retired-fetch counter
// ports: clk/reset; stall_F, flush_D, PCSrc/PCBranch in; imem_addr out, imem_q in;
//        pc_F, instr_D, pc_D, valid_D, fetch_fault, fetch_count out
module fetch_stage #(
  parameter int N = 64,
  parameter int ROM_WORDS_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_F,
  input  logic                      flush_D,
  input  logic                      PCSrc,
  input  logic [N-1:0]              PCBranch,
  output logic [ROM_WORDS_LOG2-1:0] imem_addr,
  input  logic [31:0]               imem_q,
  output logic [N-1:0]              pc_F,
  output logic [31:0]               instr_D,
  output logic [N-1:0]              pc_D,
  output logic                      valid_D,
  output logic                      fetch_fault,
  output logic [31:0]               fetch_count
);
  typedef enum logic {RUN, FAULT} state_t;
  state_t r_state;
  logic [N-1:0] r_pc, r_pc_d;
  logic [31:0] r_instr, r_count;
  logic r_valid;
  logic w_bad, w_run, w_adv, w_load, w_hold;
  assign w_bad = (|r_pc[1:0]) | (|r_pc[N-1:ROM_WORDS_LOG2+2]);
  assign w_run = r_state == RUN;
  // sequential advance: RUN, no redirect, no stall, good PC
  assign w_adv = w_run & ~PCSrc & ~stall_F & ~w_bad;
  // flush only suppresses the IF/ID load, never the PC step
  assign w_load = w_adv & ~flush_D;
  assign w_hold = w_run & ~PCSrc & stall_F & ~flush_D;
  assign imem_addr = r_pc[ROM_WORDS_LOG2+1:2];
  assign pc_F = r_pc;
  assign instr_D = r_instr;
  assign pc_D = r_pc_d;
  assign valid_D = r_valid;
  assign fetch_fault = r_state == FAULT;
  assign fetch_count = r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc <= '0;
      r_pc_d <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      if (PCSrc) r_pc <= PCBranch;
      else if (w_adv) r_pc <= r_pc + N'(4);
      if (!w_run && PCSrc) r_state <= RUN;
      else if (w_run && !PCSrc && !stall_F && w_bad) r_state <= FAULT;
      if (w_load) begin
        r_instr <= imem_q;
        r_pc_d <= r_pc;
        r_valid <= 1'b1;
        r_count <= r_count + 32'd1;
      end else if (!w_hold) begin
        r_instr <= '0;
        r_pc_d <= '0;
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the LEGv8 pipeline, directly upstream of the 64-word instruction ROM.
- Owns the PC register and drives the ROM word address; the ROM returns the 32-bit instruction combinationally in the same cycle.
- Captures the instruction and its PC into the IF/ID pipeline register for decode.
- Handles stall, branch redirect, IF/ID flush, out-of-range/misaligned fetch faulting, and a retired-fetch counter.

Parameters:
- N, 64, width of PC and branch target.
- ROM_WORDS_LOG2, 6, log2 of instruction ROM depth (words); must match the ROM address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_F  input  1  hazard unit: hold PC and IF/ID.
- flush_D  input  1  load a bubble into IF/ID.
- PCSrc  input  1  taken-branch redirect.
- PCBranch  input  N  redirect target (byte address).
- imem_addr  output  ROM_WORDS_LOG2  ROM word address, equal to pc_F[ROM_WORDS_LOG2+1:2].
- imem_q  input  32  instruction word returned by the ROM.
- pc_F  output  N  current fetch PC.
- instr_D  output  32  IF/ID instruction.
- pc_D  output  N  IF/ID PC.
- valid_D  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  stage is in FAULT state.
- fetch_count  output  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset: synchronous, active-high; one clock; the clock and reset ports are named clk and reset. While reset is high, on each rising edge: pc_F=0, instr_D=0, pc_D=0, valid_D=0, state=RUN, fetch_count=0. Reset overrides every other input.
- imem_addr is combinational from pc_F.
- bad_pc = (pc_F[1:0] != 0) OR (pc_F[N-1:ROM_WORDS_LOG2+2] != 0).
- State RUN, fetch_fault=0. Per edge, checked in priority order:
  - PCSrc=1: pc_F <= PCBranch. IF/ID takes a bubble: valid_D=0, instr_D=0, pc_D=0. Stall is ignored.
  - else stall_F=1: pc_F and IF/ID hold. flush_D still applies if asserted.
  - else bad_pc: pc_F holds, IF/ID takes a bubble, state goes to FAULT.
  - else: pc_F <= pc_F+4, modulo 2^N, no carry-out. IF/ID loads instr_D=imem_q, pc_D=pc_F, valid_D=1. fetch_count increments.
  - flush_D=1 forces a bubble in IF/ID on that edge in every case, overriding the load or the hold. The PC update is unaffected by flush_D.
- State FAULT, fetch_fault=1:
  - pc_F holds, IF/ID takes a bubble every edge, fetch_count holds.
  - PCSrc=1: pc_F <= PCBranch, state goes to RUN. A redirect target that is itself bad faults again on the following edge.
  - stall_F and flush_D have no further effect in FAULT.
- fetch_count wraps from 0xFFFFFFFF to 0.
- Latency: an instruction is at imem_q in the same cycle pc_F points at it, and reaches instr_D one edge later.

Test Plan:
- Reset, then 3 free-running edges with ROM words 0xf8000001, 0xf8008002, 0xf8000203 -> after edge 1: pc_F=4, instr_D=0xf8000001, pc_D=0, valid_D=1. After edge 3: pc_F=0xC, instr_D=0xf8000203, pc_D=8, fetch_count=3.
- stall_F=1 for 2 edges at pc_F=0x10 -> pc_F, instr_D, pc_D, fetch_count unchanged. Release -> pc_F=0x14, pc_D=0x10.
- PCSrc=1, PCBranch=0x74, with stall_F=1 simultaneously -> pc_F=0x74, valid_D=0. Next edge -> instr_D=0xb4000040, pc_D=0x74.
- flush_D=1 alone at pc_F=0x20 -> pc_F=0x24, valid_D=0, instr_D=0, fetch_count unchanged.
- PCSrc to 0x102 -> pc_F=0x102. Next edge -> fetch_fault=1, valid_D=0, pc_F=0x102. Further edges hold. PCSrc to 0x0 -> pc_F=0, fetch_fault=0.
- Sequential fetch reaching pc_F=0xFC then 0x100 -> 0x100 faults, not wraps to word 0. Assert reset mid-FAULT -> all outputs return to reset values on that edge.
